load_ext: RTL and testbench

Parametrised load-data formatter for the MEM stage: takes the raw memory read word with the low address bits, access size and signedness, and selects the addressed byte, halfword or word. It sign- or zero-extends the result to the full datapath width and flags misaligned accesses. Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so a WB-side stall never drops a load and `in_ready` has no combinational path from `out_ready`.

---
 rtl/load_ext.sv | 206 ++++++++++++++++++++
 tb/tb_load_ext.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_ext.sv
// load_ext: MEM-stage load formatter. Selects the addressed byte/half/word/dword
// from the raw read word, sign- or zero-extends it, flags misaligned or oversized
// accesses, and registers the result behind a two-slot (OUT + SKID) buffer.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// A producer holds its payload stable while valid=1 and ready=0. in_ready comes
// straight from a register (~skid valid), so it never depends on out_ready in the
// same cycle. out_data/out_misalign hold while out_valid=1 and out_ready=0.
module load_ext #(
    parameter int DATA_W     = 32,
    parameter int BIG_ENDIAN = 0,
    parameter int CNT_W      = 8,
    localparam int NB        = DATA_W / 8,
    localparam int AW        = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [AW-1:0]     in_addr_lo,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_misalign,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [1:0]        dbg_state
);

    localparam logic [3:0] NB4 = 4'(NB);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_mis;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_mis;
    logic [CNT_W-1:0]  r_err_cnt;

    logic [3:0]        w_sb;
    logic [2:0]        w_amask;
    logic              w_unalign;
    logic              w_too_big;
    logic              w_err;
    logic [3:0]        w_addr4;
    logic [3:0]        w_shift;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_keep;
    logic              w_msb;
    logic              w_ext;
    logic [DATA_W-1:0] w_fmt;
    logic [DATA_W-1:0] w_pay_data;
    logic              w_pay_mis;

    logic w_acc;
    logic w_pop;
    logic w_ld_out_in;
    logic w_ld_out_skid;
    logic w_ld_skid;

    // ---------------- combinational formatting of the incoming request ----------------
    assign w_sb      = 4'd1 << in_size;
    assign w_too_big = (w_sb > NB4);
    assign w_unalign = |(in_addr_lo & w_amask[AW-1:0]);
    assign w_err     = w_unalign | w_too_big;
    assign w_addr4   = 4'(in_addr_lo);
    // Big-endian puts byte 0 in the top lane, so the field is counted from the top.
    assign w_shift   = (BIG_ENDIAN != 0) ? (NB4 - w_sb - w_addr4) : w_addr4;
    assign w_shifted = in_rdata >> {w_shift, 3'b000};

    // Alignment mask, kept-field mask and field MSB for each access size.
    always_comb begin
        w_amask = 3'd0;
        w_keep  = '0;
        w_msb   = 1'b0;
        case (in_size)
            2'd0: begin
                w_amask     = 3'd0;
                w_keep[7:0] = '1;
                w_msb       = w_shifted[7];
            end
            2'd1: begin
                w_amask      = 3'd1;
                w_keep[15:0] = '1;
                w_msb        = w_shifted[15];
            end
            2'd2: begin
                w_amask      = 3'd3;
                w_keep[31:0] = '1;
                w_msb        = w_shifted[31];
            end
            default: begin
                w_amask = 3'd7;
                w_keep  = '1;
                w_msb   = w_shifted[DATA_W-1];
            end
        endcase
    end

    assign w_ext      = in_signed & w_msb;
    assign w_fmt      = (w_shifted & w_keep) | ({DATA_W{w_ext}} & ~w_keep);
    assign w_pay_data = w_err ? '0 : w_fmt;
    assign w_pay_mis  = w_err;

    // ---------------- buffer control ----------------
    assign w_acc = in_valid & ~r_skid_valid;
    assign w_pop = r_out_valid & out_ready;

    // Next occupancy state and which slot loads from where.
    always_comb begin
        w_next        = r_state;
        w_ld_out_in   = 1'b0;
        w_ld_out_skid = 1'b0;
        w_ld_skid     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_acc) begin
                    w_next      = S_ONE;
                    w_ld_out_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_acc && !w_pop) begin
                    w_next    = S_FULL;
                    w_ld_skid = 1'b1;
                end else if (w_acc && w_pop) begin
                    w_ld_out_in = 1'b1;
                end else if (w_pop) begin
                    w_next = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_next        = S_ONE;
                    w_ld_out_skid = 1'b1;
                end
            end
            default: begin
                w_next = S_EMPTY;
            end
        endcase
    end

    // State register plus slot-valid flags derived from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_EMPTY;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_out_valid  <= (w_next != S_EMPTY);
            r_skid_valid <= (w_next == S_FULL);
        end
    end

    // Payload slots: OUT reloads from input or SKID; SKID captures on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_mis   <= 1'b0;
            r_skid_data <= '0;
            r_skid_mis  <= 1'b0;
        end else begin
            if (w_ld_out_in) begin
                r_out_data <= w_pay_data;
                r_out_mis  <= w_pay_mis;
            end else if (w_ld_out_skid) begin
                r_out_data <= r_skid_data;
                r_out_mis  <= r_skid_mis;
            end
            if (w_ld_skid) begin
                r_skid_data <= w_pay_data;
                r_skid_mis  <= w_pay_mis;
            end
        end
    end

    // Saturating count of accepted erroneous requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_acc && w_err && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign in_ready     = ~r_skid_valid;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_misalign = r_out_mis;
    assign err_cnt      = r_err_cnt;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_load_ext.sv
// tb_load_ext: directed bench for load_ext. The main 32-bit little-endian instance
// is checked every cycle against a queue-based occupancy/ordering model; a 32-bit
// big-endian and a 64-bit instance get directed checks against literals and the model.
module tb_load_ext;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  int n_out = 0;

  // main DUT (32-bit, little-endian)
  logic        m_valid = 1'b0;
  logic        m_ready;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_addr = '0;
  logic [1:0]  m_size = '0;
  logic        m_sgn = 1'b0;
  logic        m_ovalid;
  logic        m_oready = 1'b1;
  logic [31:0] m_odata;
  logic        m_omis;
  logic [7:0]  m_err;
  logic [1:0]  m_dbg;

  // big-endian 32-bit DUT
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [31:0] b_rdata = '0;
  logic [1:0]  b_addr = '0;
  logic [1:0]  b_size = '0;
  logic        b_sgn = 1'b0;
  logic        b_ovalid;
  logic        b_oready = 1'b1;
  logic [31:0] b_odata;
  logic        b_omis;
  logic [7:0]  b_err;
  logic [1:0]  b_dbg;

  // 64-bit little-endian DUT
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [63:0] w_rdata = '0;
  logic [2:0]  w_addr = '0;
  logic [1:0]  w_size = '0;
  logic        w_sgn = 1'b0;
  logic        w_ovalid;
  logic        w_oready = 1'b1;
  logic [63:0] w_odata;
  logic        w_omis;
  logic [7:0]  w_err;
  logic [1:0]  w_dbg;

  load_ext #(.DATA_W(32), .BIG_ENDIAN(0), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(m_ready), .in_rdata(m_rdata),
    .in_addr_lo(m_addr), .in_size(m_size), .in_signed(m_sgn), .out_valid(m_ovalid),
    .out_ready(m_oready), .out_data(m_odata), .out_misalign(m_omis), .err_cnt(m_err),
    .dbg_state(m_dbg)
  );

  load_ext #(.DATA_W(32), .BIG_ENDIAN(1), .CNT_W(8)) u_be (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_rdata(b_rdata),
    .in_addr_lo(b_addr), .in_size(b_size), .in_signed(b_sgn), .out_valid(b_ovalid),
    .out_ready(b_oready), .out_data(b_odata), .out_misalign(b_omis), .err_cnt(b_err),
    .dbg_state(b_dbg)
  );

  load_ext #(.DATA_W(64), .BIG_ENDIAN(0), .CNT_W(8)) u_64 (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_ready), .in_rdata(w_rdata),
    .in_addr_lo(w_addr), .in_size(w_size), .in_signed(w_sgn), .out_valid(w_ovalid),
    .out_ready(w_oready), .out_data(w_odata), .out_misalign(w_omis), .err_cnt(w_err),
    .dbg_state(w_dbg)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference formatter: returns {misalign, data} for any width/endianness.
  function automatic logic [64:0] model_fmt(input int dw, input bit be, input logic [63:0] rd,
                                            input int off, input int size, input bit sgn);
    int sb;
    int nb;
    int sh;
    logic [63:0] r;
    sb = 1 << size;
    nb = dw / 8;
    if ((off % sb) != 0 || sb > nb) return {1'b1, 64'd0};
    sh = be ? (nb - sb - off) : off;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < sb * 8 && (sh * 8 + i) < 64) r[i] = rd[sh * 8 + i];
    end
    if (sgn) begin
      for (int i = 0; i < 64; i++) begin
        if (i >= sb * 8 && i < dw) r[i] = r[sb * 8 - 1];
      end
    end
    return {1'b0, r};
  endfunction

  // ---------------- scoreboard for the main DUT ----------------
  logic [32:0] exp_q[$];
  int exp_err = 0;

  // Every negedge: outputs against model, then advance the model for the next edge.
  always @(negedge clk) begin : monitor
    int sz;
    logic [64:0] r;
    if (mon_en) begin
      sz = exp_q.size();
      check("mon_out_valid", 64'(m_ovalid), 64'(sz != 0));
      check("mon_in_ready", 64'(m_ready), 64'(sz < 2));
      check("mon_err_cnt", 64'(m_err), 64'(exp_err));
      if (m_ovalid && sz != 0) begin
        check("mon_out_data", 64'(m_odata), 64'(exp_q[0][31:0]));
        check("mon_out_misalign", 64'(m_omis), 64'(exp_q[0][32]));
      end
      if (rst) begin
        exp_q.delete();
        exp_err = 0;
      end else begin
        if (sz != 0 && m_oready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
        if (m_valid && sz < 2) begin
          r = model_fmt(32, 1'b0, {32'd0, m_rdata}, int'(m_addr), int'(m_size), m_sgn);
          exp_q.push_back({r[64], r[31:0]});
          if (r[64] && exp_err < 255) exp_err++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic m_set(input logic [31:0] rd, input int off, input int size, input bit sgn);
    m_rdata = rd;
    m_addr  = 2'(off);
    m_size  = 2'(size);
    m_sgn   = sgn;
  endtask

  // Single load with out_ready=1; result must appear after the accepting edge.
  task automatic load_chk(input string name, input logic [31:0] rd, input int off, input int size,
                          input bit sgn, input logic [31:0] exp_d, input bit exp_m);
    m_set(rd, off, size, sgn);
    m_valid = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, 64'(m_ovalid), 64'd1);
    check({name, "_data"}, 64'(m_odata), 64'(exp_d));
    check({name, "_mis"}, 64'(m_omis), 64'(exp_m));
    @(posedge clk); #1;
  endtask

  // Present one load and hold it until accepted (bounded wait).
  task automatic push_one(input logic [31:0] rd, input int off, input int size, input bit sgn);
    bit acc;
    int t;
    m_set(rd, off, size, sgn);
    m_valid = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = m_ready;
      @(posedge clk); #1;
      t++;
    end
    m_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_err++;
      $display("FAIL push_timeout: in_ready stuck at 0 for %0d cycles", t);
    end
  endtask

  task automatic be_chk(input string name, input logic [31:0] rd, input int off, input int size,
                        input bit sgn, input logic [31:0] exp_d, input bit exp_m);
    logic [64:0] r;
    r = model_fmt(32, 1'b1, {32'd0, rd}, off, size, sgn);
    b_rdata = rd; b_addr = 2'(off); b_size = 2'(size); b_sgn = sgn;
    b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, 64'(b_ovalid), 64'd1);
    check({name, "_data"}, 64'(b_odata), 64'(exp_d));
    check({name, "_mis"}, 64'(b_omis), 64'(exp_m));
    check({name, "_model"}, 64'(b_odata), 64'(r[31:0]));
    @(posedge clk); #1;
  endtask

  task automatic w64_chk(input string name, input logic [63:0] rd, input int off, input int size,
                         input bit sgn, input logic [63:0] exp_d, input bit exp_m);
    logic [64:0] r;
    r = model_fmt(64, 1'b0, rd, off, size, sgn);
    w_rdata = rd; w_addr = 3'(off); w_size = 2'(size); w_sgn = sgn;
    w_valid = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, 64'(w_ovalid), 64'd1);
    check({name, "_data"}, w_odata, exp_d);
    check({name, "_mis"}, 64'(w_omis), 64'(exp_m));
    check({name, "_model"}, w_odata, r[63:0]);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] bp [4] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, 32'hCAFE_F00D};
  logic [31:0] mix_d [8] = '{32'h8A7B6C5D, 32'h01020304, 32'hFF00FF00, 32'h80008000,
                             32'h7F7F7F7F, 32'hDEADBEEF, 32'h00000080, 32'h55AA55AA};
  int mix_off [8]  = '{1, 2, 0, 2, 3, 0, 0, 3};
  int mix_size [8] = '{0, 1, 2, 1, 0, 3, 0, 1};
  bit mix_sgn [8]  = '{1, 1, 0, 1, 1, 0, 1, 0};
  bit rdy_pat [16] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1, 1};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int n0;
    logic [64:0] r;

    // reset
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(m_ovalid), 64'd0);
    check("rst_in_ready", 64'(m_ready), 64'd1);
    check("rst_out_data", 64'(m_odata), 64'd0);
    check("rst_out_mis", 64'(m_omis), 64'd0);
    check("rst_err_cnt", 64'(m_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // pin the model with hand-derived values
    r = model_fmt(32, 1'b0, 64'h8A7B6C5D, 3, 0, 1'b1);
    check("model_byte3_s", r[63:0], 64'h0000_0000_FFFF_FF8A);
    r = model_fmt(32, 1'b1, 64'h8A7B6C5D, 2, 1, 1'b1);
    check("model_be_half2", r[63:0], 64'h0000_0000_0000_6C5D);
    r = model_fmt(64, 1'b0, 64'hF0E0D0C0B0A09080, 4, 2, 1'b1);
    check("model_64_word4", r[63:0], 64'hFFFF_FFFF_F0E0_D0C0);
    r = model_fmt(32, 1'b0, 64'h8A7B6C5D, 1, 1, 1'b1);
    check("model_misalign", 64'(r[64]), 64'd1);

    // byte / half / word on the main DUT
    load_chk("byte0_s", 32'h8A7B6C5D, 0, 0, 1'b1, 32'h0000005D, 1'b0);
    load_chk("byte3_s", 32'h8A7B6C5D, 3, 0, 1'b1, 32'hFFFFFF8A, 1'b0);
    load_chk("byte3_u", 32'h8A7B6C5D, 3, 0, 1'b0, 32'h0000008A, 1'b0);
    load_chk("half2_s", 32'h8A7B6C5D, 2, 1, 1'b1, 32'hFFFF8A7B, 1'b0);
    load_chk("half0_s", 32'h8A7B6C5D, 0, 1, 1'b1, 32'h00006C5D, 1'b0);
    load_chk("word_s", 32'h8A7B6C5D, 0, 2, 1'b1, 32'h8A7B6C5D, 1'b0);

    // misalign and oversize
    check("err_before", 64'(m_err), 64'd0);
    load_chk("half1_err", 32'h8A7B6C5D, 1, 1, 1'b1, 32'h0, 1'b1);
    check("err_after_half1", 64'(m_err), 64'd1);
    load_chk("size3_err", 32'h8A7B6C5D, 0, 3, 1'b0, 32'h0, 1'b1);
    check("err_after_size3", 64'(m_err), 64'd2);

    // big-endian and 64-bit instances
    be_chk("be_half2", 32'h8A7B6C5D, 2, 1, 1'b1, 32'h00006C5D, 1'b0);
    be_chk("be_byte0_s", 32'h8A7B6C5D, 0, 0, 1'b1, 32'hFFFFFF8A, 1'b0);
    be_chk("be_byte3_u", 32'h8A7B6C5D, 3, 0, 1'b0, 32'h0000005D, 1'b0);
    be_chk("be_word", 32'h8A7B6C5D, 0, 2, 1'b1, 32'h8A7B6C5D, 1'b0);
    w64_chk("w64_word4_s", 64'hF0E0D0C0B0A09080, 4, 2, 1'b1, 64'hFFFFFFFFF0E0D0C0, 1'b0);
    w64_chk("w64_dword", 64'hF0E0D0C0B0A09080, 0, 3, 1'b1, 64'hF0E0D0C0B0A09080, 1'b0);
    w64_chk("w64_byte7_u", 64'hF0E0D0C0B0A09080, 7, 0, 1'b0, 64'h00000000000000F0, 1'b0);
    w64_chk("w64_half6_s", 64'hF0E0D0C0B0A09080, 6, 1, 1'b1, 64'hFFFFFFFFFFFFF0E0, 1'b0);
    w64_chk("w64_dword_err", 64'hF0E0D0C0B0A09080, 4, 3, 1'b0, 64'h0, 1'b1);
    check("w64_err_cnt", 64'(w_err), 64'd1);

    // 300 back-to-back errors saturate the counter
    m_set(32'h8A7B6C5D, 1, 1, 1'b1);
    m_valid = 1'b1;
    repeat (300) begin
      @(posedge clk); #1;
    end
    m_valid = 1'b0;
    @(negedge clk);
    check("err_saturate", 64'(m_err), 64'd255);
    repeat (3) begin
      @(posedge clk); #1;
    end

    // backpressure: 4 word loads against a stalled consumer
    n0 = n_out;
    m_oready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) push_one(bp[k], 0, 2, 1'b0);
      end
      begin
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_drop", 64'(m_ready), 64'd0);
        check("bp_head", 64'(m_odata), 64'(bp[0]));
        @(posedge clk);
        @(negedge clk);
        check("bp_head_stable", 64'(m_odata), 64'(bp[0]));
        @(posedge clk); #1;
        m_oready = 1'b1;
      end
    join
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("bp_count", 64'(n_out - n0), 64'd4);
    check("bp_drained", 64'(m_ovalid), 64'd0);

    // mixed loads against an irregular consumer
    fork
      begin
        for (int k = 0; k < 8; k++) push_one(mix_d[k], mix_off[k], mix_size[k], mix_sgn[k]);
      end
      begin
        for (int i = 0; i < 16; i++) begin
          m_oready = rdy_pat[i];
          @(posedge clk); #1;
        end
        m_oready = 1'b1;
      end
    join
    repeat (4) begin
      @(posedge clk); #1;
    end

    // reset while FULL discards both entries and the presented request
    m_oready = 1'b0;
    m_set(32'h11112222, 0, 2, 1'b0);
    m_valid = 1'b1;
    @(posedge clk); #1;
    m_set(32'h33334444, 0, 2, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    m_set(32'h8A7B6C5D, 1, 1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    m_valid = 1'b0;
    m_oready = 1'b1;
    @(negedge clk);
    check("rstfull_out_valid", 64'(m_ovalid), 64'd0);
    check("rstfull_in_ready", 64'(m_ready), 64'd1);
    check("rstfull_err_cnt", 64'(m_err), 64'd0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("rstfull_no_stale", 64'(m_ovalid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
